// File: rtl/ysyx_24090012_lsu_stage_if.sv
// ysyx_24090012_lsu_stage_if: EXU-in, memory req/resp and writeback-out bundle for the LSU stage
//   slave  : the LSU stage (consumes in_*, drives mem request, drives writeback packet)
//   master : the surroundings (EXU, memory, writeback stage)
interface ysyx_24090012_lsu_stage_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_waddr;
  logic [DATA_WIDTH-1:0] in_alu_result;
  logic [DATA_WIDTH-1:0] in_store_data;
  logic                  in_wen;
  logic                  in_mem_ren;
  logic                  in_mem_wen;
  logic [2:0]            in_funct3;
  logic [31:0]           in_next_pc;
  logic [63:0]           in_num;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [31:0]           mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wen;
  logic [31:0]           next_pc;
  logic [63:0]           num;
  logic [31:0]           sim_lsu_addr;
  modport slave (
    input  in_valid, in_waddr, in_alu_result, in_store_data, in_wen, in_mem_ren, in_mem_wen,
           in_funct3, in_next_pc, in_num, mem_req_ready, mem_resp_valid, mem_rdata, rd_ready,
    output in_ready, mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb, rd_valid,
           waddr, wdata, wen, next_pc, num, sim_lsu_addr
  );
  modport master (
    output in_valid, in_waddr, in_alu_result, in_store_data, in_wen, in_mem_ren, in_mem_wen,
           in_funct3, in_next_pc, in_num, mem_req_ready, mem_resp_valid, mem_rdata, rd_ready,
    input  in_ready, mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb, rd_valid,
           waddr, wdata, wen, next_pc, num, sim_lsu_addr
  );
endinterface

// File: rtl/ysyx_24090012_lsu_stage.sv
// ysyx_24090012_lsu_stage: single-outstanding load/store stage between EXU and writeback
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : EXU packet in, 32-bit memory req/resp, writeback packet out
module ysyx_24090012_lsu_stage (
  input logic                      clock,
  input logic                      reset,
  ysyx_24090012_lsu_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
  state_t      state, state_nxt;
  logic [2:0]  funct3;
  logic        is_mem;
  logic        take;
  logic [1:0]  ea_lo;
  logic [1:0]  off;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_data;
  assign is_mem = bus.in_mem_ren | bus.in_mem_wen;
  assign take   = state == IDLE && bus.in_valid;
  assign ea_lo  = bus.in_alu_result[1:0];
  // sim_lsu_addr holds the unaligned ea of a memory op, so its low bits select the load lane
  assign off    = bus.sim_lsu_addr[1:0];
  assign bus.in_ready      = state == IDLE;
  assign bus.mem_req_valid = state == REQ;
  assign bus.rd_valid      = state == OUT;
  assign st_strb = bus.in_funct3 == 3'b000 ? 4'b0001 << ea_lo :
                   bus.in_funct3 == 3'b001 ? (ea_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_data = bus.in_funct3 == 3'b000 ? {4{bus.in_store_data[7:0]}} :
                   bus.in_funct3 == 3'b001 ? {2{bus.in_store_data[15:0]}} : bus.in_store_data;
  assign lb = bus.mem_rdata[{off, 3'b000} +: 8];
  assign lh = off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  assign ld_data = funct3 == 3'b000 ? {{24{lb[7]}}, lb} :
                   funct3 == 3'b001 ? {{16{lh[15]}}, lh} :
                   funct3 == 3'b100 ? {24'b0, lb} :
                   funct3 == 3'b101 ? {16'b0, lh} : bus.mem_rdata;
  always_ff @(posedge clock) state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = is_mem ? REQ : OUT;
      REQ:     if (bus.mem_req_ready) state_nxt = WAIT;
      WAIT:    if (bus.mem_resp_valid) state_nxt = OUT;
      default: if (bus.rd_ready) state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      funct3           <= '0;
      bus.waddr        <= '0;
      bus.wdata        <= '0;
      bus.wen          <= 1'b0;
      bus.next_pc      <= '0;
      bus.num          <= '0;
      bus.sim_lsu_addr <= '0;
      bus.mem_addr     <= '0;
      bus.mem_we       <= 1'b0;
      bus.mem_wdata    <= '0;
      bus.mem_wstrb    <= '0;
    end else if (take) begin
      funct3           <= bus.in_funct3;
      bus.waddr        <= bus.in_waddr;
      bus.wdata        <= bus.in_alu_result;
      bus.wen          <= bus.in_wen & ~bus.in_mem_wen;
      bus.next_pc      <= bus.in_next_pc;
      bus.num          <= bus.in_num;
      bus.sim_lsu_addr <= is_mem ? bus.in_alu_result : '0;
      bus.mem_addr     <= is_mem ? {bus.in_alu_result[31:2], 2'b00} : '0;
      bus.mem_we       <= bus.in_mem_wen;
      bus.mem_wdata    <= bus.in_mem_wen ? st_data : '0;
      bus.mem_wstrb    <= bus.in_mem_wen ? st_strb : 4'b0000;
    end else if (state == WAIT && bus.mem_resp_valid && !bus.mem_we) begin
      bus.wdata        <= ld_data;
    end
  end
endmodule

// File: tb/tb_ysyx_24090012_lsu_stage.sv
// tb_ysyx_24090012_lsu_stage: vector table plus scoreboard of writeback packets
module tb_ysyx_24090012_lsu_stage;
  typedef struct {
    logic        ren;
    logic        st;
    logic [2:0]  f3;
    logic [4:0]  waddr;
    logic        wen;
    logic [31:0] ea;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_wen;
    logic [3:0]  exp_strb;
    logic [31:0] exp_mwdata;
  } vec_t;
  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [63:0] num;
    logic [31:0] next_pc;
    logic        chk_wdata;
  } pkt_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   seq = 0;
  pkt_t sb[$];
  ysyx_24090012_lsu_stage_if bus ();
  ysyx_24090012_lsu_stage dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  vec_t vecs[16] = '{
    '{1'b0, 1'b0, 3'b000, 5'd5,  1'b1, 32'h0000_1234, 32'h0,         32'h0,         32'h0000_1234, 1'b1, 4'b0000, 32'h0},
    '{1'b1, 1'b0, 3'b000, 5'd7,  1'b1, 32'h8000_0003, 32'h0,         32'h80FF_1234, 32'hFFFF_FF80, 1'b1, 4'b0000, 32'h0},
    '{1'b1, 1'b0, 3'b100, 5'd8,  1'b1, 32'h8000_0003, 32'h0,         32'h80FF_1234, 32'h0000_0080, 1'b1, 4'b0000, 32'h0},
    '{1'b1, 1'b0, 3'b001, 5'd9,  1'b1, 32'h8000_0002, 32'h0,         32'h80FF_1234, 32'hFFFF_80FF, 1'b1, 4'b0000, 32'h0},
    '{1'b1, 1'b0, 3'b101, 5'd10, 1'b1, 32'h8000_0001, 32'h0,         32'h80FF_1234, 32'h0000_1234, 1'b1, 4'b0000, 32'h0},
    '{1'b1, 1'b0, 3'b010, 5'd11, 1'b1, 32'h8000_0007, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 4'b0000, 32'h0},
    '{1'b1, 1'b0, 3'b011, 5'd12, 1'b1, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0},
    '{1'b1, 1'b0, 3'b000, 5'd13, 1'b1, 32'h0000_0001, 32'h0,         32'h80FF_1234, 32'h0000_0012, 1'b1, 4'b0000, 32'h0},
    '{1'b0, 1'b1, 3'b001, 5'd14, 1'b1, 32'h8000_0006, 32'h0000_ABCD, 32'h0,         32'h0,         1'b0, 4'b1100, 32'hABCD_ABCD},
    '{1'b0, 1'b1, 3'b000, 5'd15, 1'b1, 32'h8000_0001, 32'h1234_56A5, 32'h0,         32'h0,         1'b0, 4'b0010, 32'hA5A5_A5A5},
    '{1'b0, 1'b1, 3'b010, 5'd16, 1'b1, 32'h8000_0008, 32'h1122_3344, 32'h0,         32'h0,         1'b0, 4'b1111, 32'h1122_3344},
    '{1'b1, 1'b1, 3'b000, 5'd17, 1'b1, 32'h0000_0002, 32'h0000_0077, 32'h0,         32'h0,         1'b0, 4'b0100, 32'h7777_7777},
    '{1'b0, 1'b0, 3'b000, 5'd0,  1'b1, 32'h0000_0055, 32'h0,         32'h0,         32'h0000_0055, 1'b1, 4'b0000, 32'h0},
    '{1'b0, 1'b0, 3'b000, 5'd3,  1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 4'b0000, 32'h0},
    '{1'b0, 1'b1, 3'b001, 5'd18, 1'b0, 32'h8000_0000, 32'hFFFF_1111, 32'h0,         32'h0,         1'b0, 4'b0011, 32'h1111_1111},
    '{1'b1, 1'b0, 3'b001, 5'd19, 1'b1, 32'h0000_0003, 32'h0,         32'h7FFF_8000, 32'h0000_7FFF, 1'b1, 4'b0000, 32'h0}
  };
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_reset_state();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_wen", bus.wen, 0);
    chk("rst_next_pc", bus.next_pc, 0);
    chk("rst_num", bus.num, 0);
    chk("rst_sim_addr", bus.sim_lsu_addr, 0);
  endtask
  task automatic drive_in(input vec_t v);
    bus.in_valid      = 1'b1;
    bus.in_waddr      = v.waddr;
    bus.in_alu_result = v.ea;
    bus.in_store_data = v.sd;
    bus.in_wen        = v.wen;
    bus.in_mem_ren    = v.ren;
    bus.in_mem_wen    = v.st;
    bus.in_funct3     = v.f3;
    bus.in_num        = 64'h0000_1000_0000_0000 + 64'(seq);
    bus.in_next_pc    = 32'h8000_0000 + (32'(seq) << 2);
    seq++;
  endtask
  task automatic do_op(input vec_t v, input int req_dly, input int rd_dly, input bit noise);
    pkt_t p;
    bit   mem_op;
    mem_op = v.ren | v.st;
    chk("in_ready_idle", bus.in_ready, 1);
    drive_in(v);
    p = '{v.waddr, v.exp_wdata, v.exp_wen, bus.in_num, bus.in_next_pc, !v.st};
    sb.push_back(p);
    @(negedge clock);
    bus.in_valid = noise;
    if (noise) begin
      bus.in_waddr = 5'h1f;
      bus.in_alu_result = 32'h5A5A_5A5A;
      bus.in_num = ~bus.in_num;
      bus.in_mem_ren = 1'b0;
      bus.in_mem_wen = 1'b0;
    end
    if (mem_op) begin
      for (int i = 0; i <= req_dly; i++) begin
        bus.mem_req_ready  = (i == req_dly);
        bus.mem_resp_valid = noise && i == 0;
        bus.mem_rdata      = 32'hBAD0_BAD0;
        chk("req_valid", bus.mem_req_valid, 1);
        chk("in_ready_req", bus.in_ready, 0);
        chk("rd_valid_req", bus.rd_valid, 0);
        chk("mem_addr", bus.mem_addr, {v.ea[31:2], 2'b00});
        chk("mem_we", bus.mem_we, v.st);
        chk("mem_wstrb", bus.mem_wstrb, v.exp_strb);
        if (v.st) chk("mem_wdata", bus.mem_wdata, v.exp_mwdata);
        chk("sim_lsu_addr", bus.sim_lsu_addr, v.ea);
        @(negedge clock);
      end
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = v.rdata;
      chk("req_valid_wait", bus.mem_req_valid, 0);
      chk("rd_valid_wait", bus.rd_valid, 0);
      chk("in_ready_wait", bus.in_ready, 0);
      @(negedge clock);
      bus.mem_resp_valid = 1'b0;
    end
    for (int i = 0; i <= rd_dly; i++) begin
      bus.rd_ready = (i == rd_dly);
      if (i == rd_dly) bus.in_valid = 1'b0;
      chk("rd_valid", bus.rd_valid, 1);
      chk("in_ready_out", bus.in_ready, 0);
      chk("req_valid_out", bus.mem_req_valid, 0);
      if (!mem_op) chk("sim_addr_alu", bus.sim_lsu_addr, 0);
      chk("sb_pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        chk("waddr", bus.waddr, sb[0].waddr);
        chk("wen", bus.wen, sb[0].wen);
        chk("num", bus.num, sb[0].num);
        chk("next_pc", bus.next_pc, sb[0].next_pc);
        if (sb[0].chk_wdata) chk("wdata", bus.wdata, sb[0].wdata);
        if (i == rd_dly) void'(sb.pop_front());
      end
      @(negedge clock);
    end
    bus.rd_ready = 1'b0;
    bus.in_valid = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 0; bus.in_waddr = 0; bus.in_alu_result = 0; bus.in_store_data = 0;
    bus.in_wen = 0; bus.in_mem_ren = 0; bus.in_mem_wen = 0; bus.in_funct3 = 0;
    bus.in_next_pc = 0; bus.in_num = 0; bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
    bus.mem_rdata = 0; bus.rd_ready = 0;
    repeat (2) @(negedge clock);
    chk_reset_state();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) do_op(vecs[i], (i % 3 == 0) ? 1 : 0, i % 2, 1'b0);
    do_op(vecs[5], 3, 2, 1'b1);
    do_op(vecs[8], 3, 2, 1'b1);
    bus.rd_ready = 1'b1;
    do_op(vecs[0], 0, 0, 1'b0);
    bus.rd_ready = 1'b1;
    do_op(vecs[12], 0, 0, 1'b0);
    bus.rd_ready = 1'b1;
    do_op(vecs[13], 0, 0, 1'b0);
    chk("sb_drained", sb.size(), 0);
    drive_in(vecs[5]);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clock);
    bus.mem_req_ready = 1'b0;
    chk("wait_before_rst", bus.mem_req_valid | bus.in_ready | bus.rd_valid, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 32'h1357_9BDF;
    chk_reset_state();
    @(negedge clock);
    bus.mem_resp_valid = 1'b0;
    chk("stray_rd_valid", bus.rd_valid, 0);
    chk("stray_in_ready", bus.in_ready, 1);
    chk("stray_wdata", bus.wdata, 0);
    @(negedge clock);
    chk("stray_rd_valid2", bus.rd_valid, 0);
    do_op(vecs[0], 0, 1, 1'b0);
    chk("sb_final", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
